instr_encoder: RTL and testbench

- Inverse of the ALU operation decoder: takes a 5-bit ALU operation code plus instruction class, register and immediate fields, and builds the 32-bit RV32I instruction word.
- Writes each word into instruction memory at an auto-incrementing byte address.
- Sits between the serial program-loader front end and the instruction RAM, so programs can be streamed in as (op, operands) records.
- Uses a valid/ready input handshake and a request/ack memory write handshake.

---
 rtl/instr_encoder_pkg.sv | 48 ++++
 rtl/instr_encoder_word_build.sv | 96 +++++++++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared constants for the RV32I instruction encoder. It holds
//               the base opcodes, the ALU operation codes (the same encoding
//               the ALU operation decoder uses), the instruction-class
//               enumeration and the encoder FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // RV32I base opcodes
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // ALU operation codes shared with the ALU operation decoder
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_LUI  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_SLL  = 5'b01101;
  localparam logic [4:0] ALU_SLT  = 5'b10110;
  localparam logic [4:0] ALU_SLTU = 5'b10111;

  // Instruction class; encodings 5..7 are illegal
  typedef enum logic [2:0] {
    KIND_R     = 3'd0,
    KIND_I     = 3'd1,
    KIND_LOAD  = 3'd2,
    KIND_STORE = 3'd3,
    KIND_U     = 3'd4
  } kind_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage : instr_encoder_pkg
`default_nettype wire

// File: rtl/instr_encoder_word_build.sv
`default_nettype none
// ============================================================================
// Module      : instr_word_build
// Description : Combinational encoder. It maps an instruction class, an ALU
//               operation code and the register/immediate fields to a 32-bit
//               RV32I word, and flags records that cannot be encoded.
// Ports       : kind, alu_op, mem_f3, rd, rs1, rs2, imm  -> record fields
//               word    -> encoded instruction (valid only when !illegal)
//               illegal -> record cannot be encoded
// Revision    : 1.0 - initial release
// ============================================================================
module instr_word_build
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  alu_op,
  input  logic [2:0]  mem_f3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_alu_ok;
  logic       w_shift;
  logic       w_imm12_ok;

  // The immediate fits in signed 12 bits when bits 31..11 are all equal.
  assign w_imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);

  // alu_op -> funct3/funct7
  always_comb begin
    w_f3     = 3'b000;
    w_f7     = 7'h00;
    w_alu_ok = 1'b1;
    w_shift  = 1'b0;
    case (alu_op)
      ALU_ADD:  w_f3 = 3'b000;
      ALU_SUB:  begin w_f3 = 3'b000; w_f7 = 7'h20; end
      ALU_SLL:  begin w_f3 = 3'b001; w_shift = 1'b1; end
      ALU_SLT:  w_f3 = 3'b010;
      ALU_SLTU: w_f3 = 3'b011;
      ALU_XOR:  w_f3 = 3'b100;
      ALU_SRL:  begin w_f3 = 3'b101; w_shift = 1'b1; end
      ALU_SRA:  begin w_f3 = 3'b101; w_f7 = 7'h20; w_shift = 1'b1; end
      ALU_OR:   w_f3 = 3'b110;
      ALU_AND:  w_f3 = 3'b111;
      default:  w_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    word    = 32'h0;
    illegal = 1'b1;
    case (kind)
      KIND_R: begin
        illegal = ~w_alu_ok;
        word    = {w_f7, rs2, rs1, w_f3, rd, OP_R};
      end
      KIND_I: begin
        if (w_shift) begin
          illegal = |imm[31:5];
          word    = {w_f7, imm[4:0], rs1, w_f3, rd, OP_I};
        end else begin
          // SUB has no immediate form
          illegal = ~w_alu_ok | (alu_op == ALU_SUB) | ~w_imm12_ok;
          word    = {imm[11:0], rs1, w_f3, rd, OP_I};
        end
      end
      KIND_LOAD: begin
        illegal = (alu_op != ALU_ADD) | ~w_imm12_ok |
                  ~((mem_f3 == 3'b000) | (mem_f3 == 3'b001) | (mem_f3 == 3'b010) |
                    (mem_f3 == 3'b100) | (mem_f3 == 3'b101));
        word    = {imm[11:0], rs1, mem_f3, rd, OP_LOAD};
      end
      KIND_STORE: begin
        illegal = (alu_op != ALU_ADD) | ~w_imm12_ok | (mem_f3 > 3'b010);
        word    = {imm[11:5], rs2, rs1, mem_f3, imm[4:0], OP_STORE};
      end
      KIND_U: begin
        illegal = ((alu_op != ALU_LUI) & (alu_op != ALU_ADD)) | (|imm[11:0]);
        word    = {imm[31:12], rd, (alu_op == ALU_LUI) ? OP_LUI : OP_AUIPC};
      end
      default: begin
        illegal = 1'b1;
        word    = 32'h0;
      end
    endcase
  end

endmodule : instr_word_build
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Accepts (op, operands) records on a valid/ready interface,
//               encodes them to RV32I words and writes them to instruction
//               memory at an auto-incrementing byte address using a req/ack
//               handshake.
// Ports       : clk, reset (async, active high), clear (sync)
//               in_valid/in_ready + kind, alu_op, mem_f3, rd, rs1, rs2, imm
//               mem_we, mem_addr, mem_wdata, mem_ack
//               count (saturating), error (sticky), wrapped (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        alu_op,
  input  logic [2:0]        mem_f3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [15:0]       count,
  output logic              error,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_count;
  logic              r_error, r_wrapped;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic [ADDR_W:0]   w_addr_sum;
  logic              w_accept;

  instr_word_build u_build (
    .kind    (kind),
    .alu_op  (alu_op),
    .mem_f3  (mem_f3),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .word    (w_word),
    .illegal (w_illegal)
  );

  assign w_accept   = in_valid & (r_state == ST_IDLE);
  // Carry out of the increment marks a wrap past the last word.
  assign w_addr_sum = {1'b0, r_addr} + (ADDR_W + 1)'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= ST_IDLE;
    else if (clear) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_illegal) w_next = ST_WRITE;
      ST_WRITE: if (mem_ack) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= C_BASE;
      r_wdata   <= 32'h0;
      r_count   <= 16'h0;
      r_error   <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (clear) begin
      // Clear wins over a same-cycle ack or accept.
      r_addr    <= C_BASE;
      r_count   <= 16'h0;
      r_error   <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_illegal) r_error <= 1'b1;
        else           r_wdata <= w_word;
      end
      if (r_state == ST_WRITE && mem_ack) begin
        r_addr <= w_addr_sum[ADDR_W-1:0];
        if (w_addr_sum[ADDR_W]) r_wrapped <= 1'b1;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign error     = r_error;
  assign wrapped   = r_wrapped;

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Self-checking bench for instr_encoder (ADDR_W=4 so address
//               wrap is reachable in a few words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_ready;
  logic [2:0]        kind, mem_f3;
  logic [4:0]        alu_op, rd, rs1, rs2;
  logic [31:0]       imm;
  logic              mem_we, mem_ack, error, wrapped;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       count;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .alu_op(alu_op), .mem_f3(mem_f3),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .error(error), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  alu_op;
    logic [2:0]  mem_f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input vec_t v);
    kind = v.kind; alu_op = v.alu_op; mem_f3 = v.mem_f3;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] k, input logic [4:0] op, input logic [2:0] f3,
                              input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [31:0] im, input logic ill, input logic [31:0] w);
    vec_t v;
    v.kind = k; v.alu_op = op; v.mem_f3 = f3; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = im; v.illegal = ill; v.word = w;
    return v;
  endfunction

  logic [ADDR_W-1:0] exp_addr;
  logic [15:0]       exp_count;
  logic              exp_err;

  initial begin
    //          kind  alu       f3    rd  rs1 rs2 imm            ill  word
    vecs[0]  = mk(3'd0, 5'b00000, 3'd0, 3,  1,  2,  32'h0,         0, 32'h002081B3); // ADD
    vecs[1]  = mk(3'd0, 5'b00001, 3'd0, 5,  6,  7,  32'h0,         0, 32'h407302B3); // SUB
    vecs[2]  = mk(3'd1, 5'b00000, 3'd0, 1,  0,  9,  32'hFFFFFFFF,  0, 32'hFFF00093); // ADDI -1
    vecs[3]  = mk(3'd1, 5'b01011, 3'd0, 4,  4,  0,  32'h3,         0, 32'h40325213); // SRAI
    vecs[4]  = mk(3'd3, 5'b00000, 3'd2, 31, 1,  2,  32'h8,         0, 32'h0020A423); // SW
    vecs[5]  = mk(3'd4, 5'b01000, 3'd0, 10, 7,  3,  32'h12345000,  0, 32'h12345537); // LUI
    vecs[6]  = mk(3'd1, 5'b00001, 3'd0, 1,  1,  1,  32'h1,         1, 32'h0);        // I SUB
    vecs[7]  = mk(3'd2, 5'b00000, 3'd3, 1,  1,  1,  32'h0,         1, 32'h0);        // LOAD f3=011
    vecs[8]  = mk(3'd4, 5'b01000, 3'd0, 1,  1,  1,  32'h12345001,  1, 32'h0);        // U low bits
    vecs[9]  = mk(3'd2, 5'b00000, 3'd2, 5,  2,  0,  32'hFFFFFFFC,  0, 32'hFFC12283); // LW -4
    vecs[10] = mk(3'd4, 5'b00000, 3'd0, 1,  0,  0,  32'h00001000,  0, 32'h00001097); // AUIPC
    vecs[11] = mk(3'd5, 5'b00000, 3'd0, 1,  1,  1,  32'h0,         1, 32'h0);        // kind 5
    vecs[12] = mk(3'd1, 5'b00000, 3'd0, 1,  1,  1,  32'h00000800,  1, 32'h0);        // ADDI 2048
    vecs[13] = mk(3'd1, 5'b01101, 3'd0, 1,  1,  1,  32'h00000020,  1, 32'h0);        // SLLI 32
    vecs[14] = mk(3'd0, 5'b00110, 3'd0, 1,  2,  3,  32'h0,         0, 32'h003140B3); // XOR
    vecs[15] = mk(3'd0, 5'b11111, 3'd0, 1,  2,  3,  32'h0,         1, 32'h0);        // bad alu_op

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    kind = 0; alu_op = 0; mem_f3 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_mem_we",   32'(mem_we), 0);
    chk("rst_addr",     32'(mem_addr), 0);
    chk("rst_wdata",    mem_wdata, 0);
    chk("rst_count",    32'(count), 0);
    chk("rst_flags",    {30'h0, error, wrapped}, 0);
    reset = 1'b0;
    tick();

    // Back-to-back ADD, SUB with ack tied high: word every second cycle.
    mem_ack = 1'b1;
    present(vecs[0]);
    tick();                                  // accept ADD
    present(vecs[1]);                        // held while busy
    chk("b2b_we1",   32'(mem_we), 1);
    chk("b2b_addr1", 32'(mem_addr), 0);
    chk("b2b_data1", mem_wdata, 32'h002081B3);
    chk("b2b_rdy1",  32'(in_ready), 0);
    tick();                                  // ack
    chk("b2b_we_gap", 32'(mem_we), 0);
    chk("b2b_cnt1",   32'(count), 1);
    tick();                                  // accept SUB
    in_valid = 1'b0;
    chk("b2b_we2",   32'(mem_we), 1);
    chk("b2b_addr2", 32'(mem_addr), 4);
    chk("b2b_data2", mem_wdata, 32'h407302B3);
    tick();
    chk("b2b_cnt2",  32'(count), 2);
    chk("b2b_we_end", 32'(mem_we), 0);
    mem_ack = 1'b0;

    // Table-driven vectors, ack delayed by one cycle each.
    do_clear();
    exp_addr = 0; exp_count = 0; exp_err = 0;
    for (int i = 0; i < 16; i++) begin
      present(vecs[i]);
      tick();
      in_valid = 1'b0;
      if (!vecs[i].illegal) begin
        chk($sformatf("v%0d_we", i),   32'(mem_we), 1);
        chk($sformatf("v%0d_word", i), mem_wdata, vecs[i].word);
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(exp_addr));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_addr  = exp_addr + 4'd4;
        exp_count = exp_count + 16'd1;
        chk($sformatf("v%0d_cnt", i),  32'(count), 32'(exp_count));
        chk($sformatf("v%0d_addr_next", i), 32'(mem_addr), 32'(exp_addr));
        chk($sformatf("v%0d_err", i),  32'(error), 32'(exp_err));
      end else begin
        exp_err = 1'b1;
        chk($sformatf("v%0d_ill_we", i),  32'(mem_we), 0);
        chk($sformatf("v%0d_ill_err", i), 32'(error), 1);
        chk($sformatf("v%0d_ill_cnt", i), 32'(count), 32'(exp_count));
        chk($sformatf("v%0d_ill_addr", i), 32'(mem_addr), 32'(exp_addr));
        chk($sformatf("v%0d_ill_rdy", i), 32'(in_ready), 1);
      end
    end

    // Stall: ack low for 5 cycles, everything held.
    do_clear();
    present(vecs[5]);
    tick();
    in_valid = 1'b1;                         // upstream keeps offering a record
    present(vecs[0]);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_we", c),   32'(mem_we), 1);
      chk($sformatf("stall%0d_addr", c), 32'(mem_addr), 0);
      chk($sformatf("stall%0d_data", c), mem_wdata, 32'h12345537);
      chk($sformatf("stall%0d_rdy", c),  32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;
    chk("stall_cnt", 32'(count), 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stall_done_cnt",  32'(count), 1);
    chk("stall_done_addr", 32'(mem_addr), 4);

    // Wrap: five words at 0,4,8,12,0.
    do_clear();
    mem_ack = 1'b1;
    for (int w = 0; w < 5; w++) begin
      present(vecs[0]);
      tick();
      in_valid = 1'b0;
      chk($sformatf("wrap%0d_addr", w), 32'(mem_addr), 32'((w * 4) % 16));
      tick();
      chk($sformatf("wrap%0d_flag", w), 32'(wrapped), (w >= 3) ? 1 : 0);
    end
    chk("wrap_cnt", 32'(count), 5);

    // Clear mid-WRITE with a simultaneous ack: clear wins.
    mem_ack = 1'b0;
    present(vecs[14]);
    tick();
    in_valid = 1'b0;
    chk("clr_pre_we", 32'(mem_we), 1);
    clear = 1'b1; mem_ack = 1'b1;
    tick();
    clear = 1'b0; mem_ack = 1'b0;
    chk("clr_we",    32'(mem_we), 0);
    chk("clr_addr",  32'(mem_addr), 0);
    chk("clr_cnt",   32'(count), 0);
    chk("clr_flags", {30'h0, error, wrapped}, 0);
    chk("clr_rdy",   32'(in_ready), 1);

    // Asynchronous reset mid-WRITE aborts immediately.
    present(vecs[2]);
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_we",  32'(mem_we), 0);
    chk("arst_rdy", 32'(in_ready), 1);
    chk("arst_data", mem_wdata, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_encoder
`default_nettype wire
